imem_responder: RTL and testbench

//  Memory-side responder for the CPU instruction-fetch interface: accepts a fetch

---
 rtl/imem_responder_pkg.sv | 9 +
 rtl/imem_responder_if.sv | 13 +
 rtl/imem_responder_array.sv | 19 +
 rtl/imem_responder.sv | 75 +++++++
 tb/tb_imem_responder.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/imem_responder_pkg.sv
// imem_responder_pkg: shared types, constants and range helper for the instruction memory responder
package npc_mem_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] IMEM_BASE = 32'h8000_0000;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  function automatic logic in_range(logic [XLEN-1:0] addr, logic [XLEN-1:0] base, int unsigned depth);
    return (addr[1:0] == 2'b00) && (addr >= base) && (33'(addr) < 33'(base) + (33'(depth) << 2));
  endfunction
endpackage

// File: rtl/imem_responder_if.sv
// imem_responder_if: fetch request/response handshake between CPU (master) and memory (slave)
interface imem_responder_if;
  import npc_mem_pkg::*;
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;
  modport master (output req_valid, req_addr, rsp_ready, input req_ready, rsp_valid, rsp_data, rsp_err);
  modport slave (input req_valid, req_addr, rsp_ready, output req_ready, rsp_valid, rsp_data, rsp_err);
endinterface

// File: rtl/imem_responder_array.sv
// imem_array: word array with one registered read port and one write port, read-before-write
module imem_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i
);
  logic [31:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/imem_responder.sv
// imem_responder: fixed-latency instruction fetch responder with a loader write port
module imem_responder import npc_mem_pkg::*; #(
  parameter int unsigned     DEPTH   = 1024,
  parameter logic [XLEN-1:0] BASE    = IMEM_BASE,
  parameter int unsigned     LATENCY = 1
) (
  input logic            clk,
  input logic            rst,
  imem_responder_if.slave bus,
  input logic            ld_en_i,
  input logic [XLEN-1:0] ld_addr_i,
  input logic [XLEN-1:0] ld_data_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d, rd_addr, rdata;
  logic err_q, err_d, ready, accept, enter_resp, valid;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    ready = 1'b0;
    case (state_q)
      IDLE: ready = 1'b1;
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? RESP : WAIT;
      end
      RESP: begin
        ready = bus.rsp_ready;
        state_d = bus.rsp_ready ? IDLE : RESP;
      end
      default: state_d = IDLE;
    endcase
    accept = bus.req_valid & ready;
    if (accept) begin
      addr_d = bus.req_addr;
      cnt_d = CW'(LATENCY - 1);
      state_d = (LATENCY == 1) ? RESP : WAIT;
    end
    // single-cycle latency reads the live request address, longer ones the latched copy
    enter_resp = (state_q == WAIT && cnt_q == CW'(1)) || (accept && LATENCY == 1);
    rd_addr = (state_q == WAIT) ? addr_q : bus.req_addr;
    err_d = enter_resp ? !in_range(rd_addr, BASE, DEPTH) : err_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      err_q <= err_d;
    end
  end
  imem_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .re_i    (enter_resp),
    .raddr_i (AW'((rd_addr - BASE) >> 2)),
    .rdata_o (rdata),
    .we_i    (ld_en_i && in_range(ld_addr_i, BASE, DEPTH)),
    .waddr_i (AW'((ld_addr_i - BASE) >> 2)),
    .wdata_i (ld_data_i)
  );
  assign valid = state_q == RESP;
  assign bus.req_ready = ready;
  assign bus.rsp_valid = valid;
  assign bus.rsp_err = valid & err_q;
  assign bus.rsp_data = (valid && !err_q) ? rdata : '0;
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed and random fetch traffic on latency 1/3/4 responders against a transaction model
module tb_imem_responder;
  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE = 32'h8000_0000;
  int lats [3] = '{1, 3, 4};
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, rsp_ready = 1'b0, ld_en = 1'b0;
  logic [31:0] req_addr = '0, ld_addr = '0, ld_data = '0;
  int sel = 0;
  int checks = 0, errors = 0;
  logic o_rv, o_rr, o_re;
  logic [31:0] o_rd;
  imem_responder_if b1 ();
  imem_responder_if b3 ();
  imem_responder_if b4 ();
  assign b1.req_valid = req_valid && sel == 0;
  assign b3.req_valid = req_valid && sel == 1;
  assign b4.req_valid = req_valid && sel == 2;
  assign b1.req_addr = req_addr;
  assign b3.req_addr = req_addr;
  assign b4.req_addr = req_addr;
  assign b1.rsp_ready = rsp_ready || sel != 0;
  assign b3.rsp_ready = rsp_ready || sel != 1;
  assign b4.rsp_ready = rsp_ready || sel != 2;
  assign o_rv = sel == 0 ? b1.rsp_valid : sel == 1 ? b3.rsp_valid : b4.rsp_valid;
  assign o_rr = sel == 0 ? b1.req_ready : sel == 1 ? b3.req_ready : b4.req_ready;
  assign o_re = sel == 0 ? b1.rsp_err : sel == 1 ? b3.rsp_err : b4.rsp_err;
  assign o_rd = sel == 0 ? b1.rsp_data : sel == 1 ? b3.rsp_data : b4.rsp_data;
  imem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(1)) u1 (.clk(clk), .rst(rst), .bus(b1), .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data));
  imem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(3)) u3 (.clk(clk), .rst(rst), .bus(b3), .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data));
  imem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(4)) u4 (.clk(clk), .rst(rst), .bus(b4), .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data));
  always #5 clk = ~clk;
  logic [31:0] mem [int];
  logic [31:0] vals [16];
  bit pend, show, show_err;
  logic [31:0] pend_addr, show_data;
  int pend_due, cyc = 0;
  function automatic bit ok(logic [31:0] a);
    longint la, lb;
    la = {32'b0, a};
    lb = {32'b0, BASE};
    return (la % 4 == 0) && la >= lb && la < lb + 4 * longint'(DEPTH);
  endfunction
  function automatic int idx(logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic form(input logic [31:0] a);
    show = 1'b1;
    show_err = !ok(a);
    show_data = show_err ? 32'h0 : mem[idx(a)];
  endtask
  task automatic step(input logic v, input logic [31:0] a, input logic rr, input logic le, input logic [31:0] la, input logic [31:0] lv);
    bit acc, exp_rdy;
    req_valid = v; req_addr = a; rsp_ready = rr; ld_en = le; ld_addr = la; ld_data = lv;
    #1;
    exp_rdy = !pend && (!show || rr);
    chk("rsp_valid", {31'b0, o_rv}, {31'b0, show});
    chk("req_ready", {31'b0, o_rr}, {31'b0, exp_rdy});
    chk("rsp_err", {31'b0, o_re}, {31'b0, show && show_err});
    chk("rsp_data", o_rd, show ? show_data : 32'h0);
    acc = v && exp_rdy;
    @(posedge clk);
    cyc++;
    if (show && rr) show = 1'b0;
    if (pend && pend_due == cyc) begin
      form(pend_addr);
      pend = 1'b0;
    end
    if (acc) begin
      if (lats[sel] == 1) form(a);
      else begin
        pend = 1'b1;
        pend_addr = a;
        pend_due = cyc + lats[sel] - 1;
      end
    end
    if (le && ok(la)) mem[idx(la)] = lv;
    #1;
  endtask
  task automatic do_reset(input int s);
    req_valid = 1'b0; rsp_ready = 1'b0; ld_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_rsp_valid", {31'b0, o_rv}, 32'h0);
    chk("rst_req_ready", {31'b0, o_rr}, 32'h1);
    chk("rst_rsp_data", o_rd, 32'h0);
    @(posedge clk);
    #1;
    sel = s;
    rst = 1'b0;
    pend = 1'b0;
    show = 1'b0;
    #1;
  endtask
  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom % 8;
    return r < 5 ? BASE + 4 * ($urandom % 16) :
           r == 5 ? BASE + 4 * (DEPTH - 1) :
           r == 6 ? BASE + 4 * ($urandom % 16) + 1 + $urandom % 3 :
           ($urandom % 2) ? BASE - 4 : BASE + 4 * DEPTH + 4 * ($urandom % 4);
  endfunction
  initial begin
    do_reset(0);
    for (int i = 0; i < 16; i++) vals[i] = (i == 0) ? 32'h0000_0413 : $urandom;
    for (int i = 0; i < 16; i++) step(0, 0, 1, 1, BASE + 4 * i, vals[i]);
    step(0, 0, 1, 1, BASE + 4 * (DEPTH - 1), 32'hC0DE_F00D);
    step(1, BASE, 1, 0, 0, 0);
    chk("t1_valid", {31'b0, o_rv}, 32'h1);
    chk("t1_data", o_rd, 32'h0000_0413);
    chk("t1_err", {31'b0, o_re}, 32'h0);
    step(0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(1, BASE + 4 * k, 1, 0, 0, 0);
      chk("t3_valid", {31'b0, o_rv}, 32'h1);
      chk("t3_data", o_rd, vals[k]);
    end
    step(0, 0, 1, 0, 0, 0);
    step(1, BASE + 2, 1, 0, 0, 0);
    chk("t4_mis_err", {31'b0, o_re}, 32'h1);
    chk("t4_mis_data", o_rd, 32'h0);
    step(1, 32'h7FFF_FFFC, 1, 0, 0, 0);
    chk("t4_low_err", {31'b0, o_re}, 32'h1);
    step(1, BASE + 4 * DEPTH, 1, 0, 0, 0);
    chk("t4_high_err", {31'b0, o_re}, 32'h1);
    step(1, BASE + 4 * (DEPTH - 1), 1, 0, 0, 0);
    chk("t4_last_err", {31'b0, o_re}, 32'h0);
    chk("t4_last_data", o_rd, 32'hC0DE_F00D);
    step(0, 0, 1, 1, BASE + 1, 32'hFFFF_FFFF);
    step(1, BASE, 1, 0, 0, 0);
    chk("t4_ld_drop", o_rd, 32'h0000_0413);
    step(0, 0, 1, 0, 0, 0);
    step(1, BASE + 20, 1, 1, BASE + 20, 32'hDEAD_BEEF);
    chk("t5_old", o_rd, vals[5]);
    step(1, BASE + 20, 1, 0, 0, 0);
    chk("t5_new", o_rd, 32'hDEAD_BEEF);
    step(0, 0, 1, 0, 0, 0);
    do_reset(1);
    step(1, BASE + 4, 0, 0, 0, 0);
    chk("t2_rdy_w1", {31'b0, o_rr}, 32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("t2_rdy_w2", {31'b0, o_rr}, 32'h0);
    chk("t2_novalid", {31'b0, o_rv}, 32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("t2_valid", {31'b0, o_rv}, 32'h1);
    chk("t2_data", o_rd, vals[1]);
    for (int k = 0; k < 4; k++) begin
      step(1, BASE + 8, 0, 0, 0, 0);
      chk("t2_hold_data", o_rd, vals[1]);
      chk("t2_hold_rdy", {31'b0, o_rr}, 32'h0);
    end
    step(0, 0, 1, 0, 0, 0);
    do_reset(2);
    step(1, BASE + 8, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    do_reset(2);
    for (int k = 0; k < 5; k++) step(0, 0, 1, 0, 0, 0);
    step(1, BASE + 8, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 0, 0);
    chk("t6_valid", {31'b0, o_rv}, 32'h1);
    chk("t6_retained", o_rd, vals[2]);
    step(0, 0, 1, 0, 0, 0);
    for (int s = 0; s < 3; s++) begin
      do_reset(s);
      for (int n = 0; n < 300; n++)
        step($urandom % 4 != 0, rnd_addr(), $urandom % 3 != 0, $urandom % 4 == 0,
             ($urandom % 3 == 0) ? rnd_addr() : BASE + 4 * ($urandom % 16), $urandom);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
